// File: rtl/alu_nibble_sequencer.sv
// Sequences one wide add/sub/logic operation through an external 4-bit ALU, one nibble per pass.
// Optional ALU_SEQ_ZERO_FLAG_EN adds a registered zero_flag output held alongside result.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [2:0]   alu_sel,
    input  logic [3:0]   alu_out,
    input  logic         alu_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic         zero_flag
`endif
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;
    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [W-1:0]     opa_q;
    logic [W-1:0]     opb_q;
    logic [W-1:0]     acc;
    logic [IDX_W-1:0] idx;
    logic             chain;
    logic             c1_q;

    logic             is_arith;
    logic [SH_W-1:0]  shamt;
    logic [3:0]       opa_nib;
    logic [3:0]       opb_nib;
    logic [3:0]       acc_nib;
    logic [W-1:0]     acc_upd;
    logic             c1;
    logic             chain_nxt;
    logic             last;

    // Nibble selection and accumulator merge for the current index
    always_comb begin
        is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
        shamt     = {idx, 2'b00};
        opa_nib   = 4'(opa_q >> shamt);
        opb_nib   = 4'(opb_q >> shamt);
        acc_nib   = 4'(acc >> shamt);
        acc_upd   = (acc & ~(W'(4'hF) << shamt)) | (W'(alu_out) << shamt);
        c1        = is_arith & alu_carry;
        // A second pass carries out if either the operand pass or the +/-1 pass did
        chain_nxt = (state == PASS2) ? (c1_q | alu_carry) : c1;
        last      = (idx == IDX_W'(NIBBLES - 1));
    end

    // ALU drive is a pure decode of the registered state
    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_sel = 3'b000;
        case (state)
            PASS1: begin
                alu_a   = opa_nib;
                alu_b   = opb_nib;
                alu_sel = op_q;
            end
            PASS2: begin
                alu_a   = acc_nib;
                alu_b   = 4'b0001;
                alu_sel = op_q;
            end
            default: ;
        endcase
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 3'b000;
            opa_q     <= '0;
            opb_q     <= '0;
            acc       <= '0;
            idx       <= '0;
            chain     <= 1'b0;
            c1_q      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        opa_q <= opa;
                        opb_q <= opb;
                        idx   <= '0;
                        chain <= 1'b0;
                        state <= PASS1;
                    end
                end
                PASS1, PASS2: begin
                    acc <= acc_upd;
                    if (state == PASS1 && is_arith && chain) begin
                        c1_q  <= c1;
                        state <= PASS2;
                    end else begin
                        chain <= chain_nxt;
                        if (last) begin
                            result    <= acc_upd;
                            carry_out <= is_arith & chain_nxt;
                            out_valid <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                            zero_flag <= (acc_upd == '0);
`endif
                            state     <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= PASS1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer with a behavioural 4-bit ALU and a wide-arithmetic reference.
module tb_alu_nibble_sequencer;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [2:0]   alu_sel;
    logic [3:0]   alu_out;
    logic         alu_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         zero_flag;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_res;
    logic         exp_cy;
    int           exp_k;
    logic [10:0]  exp_q[$];

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .opa(opa),
        .opb(opb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .carry_out(carry_out),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_sel(alu_sel),
        .alu_out(alu_out),
        .alu_carry(alu_carry)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .zero_flag(zero_flag)
`endif
    );

    // The 4-bit combinational ALU the sequencer drives
    always_comb begin
        alu_out   = 4'h0;
        alu_carry = 1'b0;
        case (alu_sel)
            3'b000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            3'b101: alu_out = ~alu_a;
            default: ;
        endcase
    end

    // Wide result from plain arithmetic, plus the expected per-cycle ALU drive sequence
    task automatic build_expect(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua, ub, an, bn, lo_a, lo_b, m, part;
        logic [W:0] full;
        bit cin;
        ua = 32'(a);
        ub = 32'(b);
        exp_q.delete();
        exp_k = 0;
        full = '0;
        case (o)
            3'b000: begin full = {1'b0, a} + {1'b0, b}; exp_res = full[W-1:0]; exp_cy = full[W]; end
            3'b001: begin exp_res = a - b; exp_cy = (ua < ub); end
            3'b010: begin exp_res = a & b; exp_cy = 1'b0; end
            3'b011: begin exp_res = a | b; exp_cy = 1'b0; end
            3'b100: begin exp_res = a ^ b; exp_cy = 1'b0; end
            3'b101: begin exp_res = ~a;    exp_cy = 1'b0; end
            default: begin exp_res = '0;   exp_cy = 1'b0; end
        endcase
        for (int i = 0; i < NIB; i++) begin
            an = (ua >> (4 * i)) & 32'hF;
            bn = (ub >> (4 * i)) & 32'hF;
            exp_q.push_back({4'(an), 4'(bn), o});
            if ((o == 3'b000 || o == 3'b001) && i > 0) begin
                m    = (32'd1 << (4 * i)) - 32'd1;
                lo_a = ua & m;
                lo_b = ub & m;
                cin  = (o == 3'b000) ? (((lo_a + lo_b) >> (4 * i)) != 0) : (lo_a < lo_b);
                if (cin) begin
                    part = (o == 3'b000) ? ((an + bn) & 32'hF) : ((an - bn) & 32'hF);
                    exp_q.push_back({4'(part), 4'd1, o});
                    exp_k++;
                end
            end
        end
    endtask

    // Issue one request, follow every ALU pass, then apply backpressure and complete the handshake
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit busy_req, input string tag);
        int wait_cnt;
        int lat;
        logic [10:0] e;
        build_expect(o, a, b);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        opa       = a;
        opb       = b;
        out_ready = 1'b0;
        wait_cnt  = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_timeout in_ready=%b want 1", tag, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        op       = 3'($urandom);
        opa      = W'($urandom);
        opb      = W'($urandom);
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s extra_pass alu_a=%h alu_b=%h alu_sel=%b want no pass", tag, alu_a, alu_b, alu_sel);
            end else begin
                e = exp_q.pop_front();
                if ({alu_a, alu_b, alu_sel} !== e) begin
                    errors++;
                    $display("FAIL %s alu_drive a/b/sel=%h/%h/%b want %h/%h/%b",
                             tag, alu_a, alu_b, alu_sel, e[10:7], e[6:3], e[2:0]);
                end
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid_timeout out_valid=%b want 1", tag, out_valid);
            return;
        end
        checks++;
        if (lat != NIB + exp_k + 1) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", tag, lat, NIB + exp_k + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_passes got %0d left want 0", tag, exp_q.size());
        end
        checks++;
        if (result !== exp_res || carry_out !== exp_cy || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s result=%h carry=%b in_ready=%b want %h %b 0",
                     tag, result, carry_out, in_ready, exp_res, exp_cy);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        checks++;
        if (zero_flag !== (exp_res == '0)) begin
            errors++;
            $display("FAIL %s zero_flag=%b want %b", tag, zero_flag, (exp_res == '0));
        end
`endif
        for (int h = 0; h < hold; h++) begin
            if (busy_req) begin
                in_valid = 1'b1;
                op       = 3'b000;
                opa      = W'($urandom);
                opb      = W'($urandom);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== exp_res || carry_out !== exp_cy || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d out_valid=%b result=%h carry=%b in_ready=%b want 1 %h %b 0",
                         tag, h, out_valid, result, carry_out, in_ready, exp_res, exp_cy);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_res || carry_out !== exp_cy) begin
            errors++;
            $display("FAIL %s handshake out_valid=%b in_ready=%b result=%h carry=%b want 0 1 %h %b",
                     tag, out_valid, in_ready, result, carry_out, exp_res, exp_cy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'b000;
        opa       = '0;
        opb       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || carry_out !== 1'b0 ||
            alu_a !== 4'h0 || alu_b !== 4'h0 || alu_sel !== 3'b000) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b result=%h carry=%b alu=%h/%h/%b want 1 0 0 0 0/0/0",
                     in_ready, out_valid, result, carry_out, alu_a, alu_b, alu_sel);
        end
    endtask

    task automatic test_add();
        run_op(3'b000, 16'h00FF, 16'h0001, 0, 1'b0, "add_00ff_1");
        run_op(3'b000, 16'hFFFF, 16'h0001, 0, 1'b0, "add_ffff_1");
    endtask

    task automatic test_sub();
        run_op(3'b001, 16'h0000, 16'h0001, 0, 1'b0, "sub_0_1");
        run_op(3'b001, 16'h1234, 16'h0234, 0, 1'b0, "sub_1234_0234");
    endtask

    task automatic test_logic();
        run_op(3'b100, 16'hA5C3, 16'hFFFF, 0, 1'b0, "xor");
        run_op(3'b101, 16'h1234, 16'h5555, 0, 1'b0, "not");
        run_op(3'b010, 16'hF0F0, 16'h3C3C, 0, 1'b0, "and");
        run_op(3'b011, 16'hF000, 16'h000F, 0, 1'b0, "or");
        run_op(3'b110, 16'hFFFF, 16'hFFFF, 0, 1'b0, "reserved_110");
        run_op(3'b111, 16'h1234, 16'h4321, 0, 1'b0, "reserved_111");
    endtask

    task automatic test_backpressure();
        run_op(3'b000, 16'h7FFF, 16'h0001, 5, 1'b1, "backpressure");
    endtask

    task automatic test_reset_mid_op();
        bit saw_valid;
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'b000;
        opa      = 16'hFFFF;
        opb      = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (alu_b !== 4'b0001 || alu_a !== 4'hF) begin
            errors++;
            $display("FAIL rst_mid_pass2 alu_a=%h alu_b=%h want f 1", alu_a, alu_b);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || alu_sel !== 3'b000 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state in_ready=%b out_valid=%b result=%h alu_sel=%b carry=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, alu_sel, carry_out);
        end
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL rst_mid_abandon out_valid seen=1 want 0");
        end
        run_op(3'b000, 16'h0001, 16'h0001, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            a = W'($urandom);
            b = W'($urandom);
            if (n % 4 == 0) b = ~a + W'(1);
            run_op(o, a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'b001, 16'h8000, 16'h0001, 0, 1'b0, "b2b_sub");
        run_op(3'b000, 16'h0F0F, 16'h00F1, 0, 1'b0, "b2b_add");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Initiator for the team's 4-bit combinational ALU. It owns the ALU's operand/select inputs and consumes its result/carry outputs.
- Executes one wide (4*NIBBLES-bit) operation per request by issuing one or two single-cycle ALU passes per nibble, LSB nibble first.
- Chains carry or borrow across nibbles with an extra increment/decrement pass, because the ALU has no carry-in.
- Valid/ready handshake on both the request side and the result side.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles; operand/result width W = 4*NIBBLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- op  input  3  ALU select code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110/111 reserved
- opa  input  W  operand A
- opb  input  W  operand B
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- result  output  W  wide result
- carry_out  output  1  final carry (add), final borrow (sub), 0 otherwise
- alu_a  output  4  ALU operand A
- alu_b  output  4  ALU operand B
- alu_sel  output  3  ALU select
- alu_out  input  4  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_carry  input  1  ALU carry/borrow, combinational

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.

Reset:
- State goes to IDLE.
- out_valid=0, result=0, carry_out=0, alu_a=0, alu_b=0, alu_sel=0.
- Internal nibble index, chain bit and accumulator are cleared.
- Reset mid-operation abandons the operation. No result is produced.

States: IDLE, PASS1, PASS2, DONE.

IDLE:
- in_ready=1. The alu_* outputs are 0.
- On accept: latch op/opa/opb, index=0, chain=0, then go to PASS1.
- Input changes after accept are ignored.

PASS1:
- alu_a = opa nibble[index], alu_b = opb nibble[index], alu_sel = op.
- At the clock edge, accumulator nibble[index] = alu_out.
- For add/sub, c1 = alu_carry. For other ops, c1 = 0.
- If op is add/sub and chain=1: hold c1, go to PASS2.
- Otherwise: chain = c1; index++, or go to DONE if index == NIBBLES-1.

PASS2 (add/sub only):
- alu_a = accumulator nibble[index], alu_b = 4'b0001, alu_sel = op.
- At the clock edge, accumulator nibble[index] = alu_out and chain = c1 | alu_carry.
- Then advance the index or go to DONE, as in PASS1.

DONE entry:
- result = accumulator. carry_out = chain for add/sub, 0 otherwise. out_valid=1.

DONE:
- in_ready=0. Hold result/carry_out/out_valid stable until out_ready, then go to IDLE with out_valid=0.
- result/carry_out keep their value until the next DONE entry.

Timing and encoding rules:
- alu_* outputs are combinational decodes of state registers. Each pass is exactly one cycle.
- Latency from accept to out_valid = NIBBLES + k + 1 cycles, where k is the number of PASS2 visits (0..NIBBLES-1).
- Logic ops always take exactly NIBBLES passes.
- Reserved ops are passed through to the ALU. They produce result 0 and carry_out 0.
- Sub borrow convention: the ALU's 5-bit A-B MSB is the borrow. carry_out=1 means opa < opb unsigned. result is opa-opb mod 2^W.
- No overlap: a new request can be accepted no earlier than the cycle after the result handshake.

Optional Feature:
- Macro: ALU_SEQ_ZERO_FLAG_EN.
- When defined: extra output zero_flag (1 bit). It is registered at DONE entry as (accumulator == 0), reset 0, and held with result.
- When undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan (NIBBLES=4):
- add 0x00FF + 0x0001 -> result 0x0100, carry_out 0; PASS2 visits = 2 (nibbles 1, 2); out_valid 7 cycles after accept.
- add 0xFFFF + 0x0001 -> result 0x0000, carry_out 1; PASS2 visits = 3; alu_b = 4'b0001 observed in each PASS2.
- sub 0x0000 - 0x0001 -> result 0xFFFF, carry_out 1; sub 0x1234 - 0x0234 -> 0x1000, carry_out 0.
- xor 0xA5C3 ^ 0xFFFF -> 0x5A3C, carry_out 0, exactly 4 passes; not 0x1234 -> 0xEDCB; op 110 -> 0x0000, carry_out 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/carry_out/out_valid stable, in_ready=0; in_valid asserted meanwhile is not accepted until after the handshake.
- Reset: assert rst for 1 cycle during a PASS2 of 0xFFFF+0x0001 -> next cycle IDLE, in_ready=1, out_valid=0, result=0, alu_sel=0; the following request 0x0001+0x0001 -> 0x0002.
